// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - binary32 field widths, constants and pipeline record for fp_mul
package fp_mul_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int EXPS_W = 10;

  localparam logic [EXP_W-1:0] BIAS    = 8'd127;
  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [31:0]      POS_INF = 32'h7F80_0000;
  localparam logic [31:0]      NEG_INF = 32'hFF80_0000;

  typedef enum logic [1:0] {
    SP_NONE,
    SP_NAN,
    SP_INF,
    SP_ZERO
  } sp_code_t;

  // Stage 1 packs both significands into sig as {sig_a, sig_b}; stage 2 holds the product there.
  typedef struct packed {
    logic                valid;
    logic                sign;
    logic [EXPS_W-1:0]   exp;
    logic [PROD_W-1:0]   sig;
    sp_code_t            sp;
  } pipe_rec_t;
endpackage

// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - normalize, round-to-nearest-even and pack a 48-bit significand product
module fp_round_pack
  import fp_mul_pkg::*;
(
  input  logic [PROD_W-1:0] i_prod,
  input  logic [EXPS_W-1:0] i_exp,
  input  logic              i_sign,
  output logic [31:0]       o_word
);
  logic              w_norm;
  logic [EXPS_W-1:0] w_exp_n;
  logic [EXPS_W-1:0] w_exp_r;
  logic [FRAC_W-1:0] w_frac;
  logic              w_g;
  logic              w_r;
  logic              w_s;
  logic              w_inc;
  logic [FRAC_W:0]   w_fsum;

  assign w_norm  = i_prod[PROD_W-1];
  assign w_exp_n = i_exp + {{(EXPS_W-1){1'b0}}, w_norm};
  assign w_frac  = w_norm ? i_prod[46:24] : i_prod[45:23];
  assign w_g     = w_norm ? i_prod[23] : i_prod[22];
  assign w_r     = w_norm ? i_prod[22] : i_prod[21];
  assign w_s     = w_norm ? (|i_prod[21:0]) : (|i_prod[20:0]);
  assign w_inc   = w_g & (w_r | w_s | w_frac[0]);

  // A fraction carry-out means 1.111..1 rounded up to 10.0: fraction wraps to zero, exponent bumps.
  assign w_fsum  = {1'b0, w_frac} + {{FRAC_W{1'b0}}, w_inc};
  assign w_exp_r = w_exp_n + {{(EXPS_W-1){1'b0}}, w_fsum[FRAC_W]};

  always_comb begin
    o_word = {i_sign, w_exp_r[EXP_W-1:0], w_fsum[FRAC_W-1:0]};
    if ($signed(w_exp_r) >= $signed(10'sd255)) begin
      o_word = i_sign ? NEG_INF : POS_INF;
    end else if ($signed(w_exp_r) <= $signed(10'sd0)) begin
      o_word = {i_sign, 31'd0};
    end
  end
endmodule

// File: rtl/fp_mul.sv
// rtl/fp_mul.sv - 3-cycle fully pipelined binary32 multiplier (flush-to-zero, RNE)
module fp_mul
  import fp_mul_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        A_valid,
  input  logic [31:0] A,
  input  logic        B_valid,
  input  logic [31:0] B,
  output logic        R_valid,
  output logic [31:0] R
);
  logic [EXP_W-1:0]  w_ea;
  logic [EXP_W-1:0]  w_eb;
  logic [FRAC_W-1:0] w_fa;
  logic [FRAC_W-1:0] w_fb;
  logic              w_a_zero, w_a_inf, w_a_nan;
  logic              w_b_zero, w_b_inf, w_b_nan;
  pipe_rec_t         w_s1;
  logic [PROD_W-1:0] w_prod;
  logic [31:0]       w_rounded;
  logic [31:0]       w_s3_word;

  pipe_rec_t         r_s1;
  pipe_rec_t         r_s2;
  logic              r_s3_valid;
  logic [31:0]       r_s3_word;

  assign w_ea = A[30:23];
  assign w_eb = B[30:23];
  assign w_fa = A[22:0];
  assign w_fb = B[22:0];

  // Subnormals have a zero exponent field and therefore classify as zero.
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) && (w_fa == '0);
  assign w_b_inf  = (&w_eb) && (w_fb == '0);
  assign w_a_nan  = (&w_ea) && (w_fa != '0);
  assign w_b_nan  = (&w_eb) && (w_fb != '0);

  always_comb begin
    w_s1       = '0;
    w_s1.valid = A_valid & B_valid;
    w_s1.sign  = A[31] ^ B[31];
    w_s1.exp   = {2'b00, w_ea} + {2'b00, w_eb} - {2'b00, BIAS};
    w_s1.sig   = {1'b1, w_fa, 1'b1, w_fb};
    if (w_a_nan || w_b_nan)                          w_s1.sp = SP_NAN;
    else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) w_s1.sp = SP_NAN;
    else if (w_a_inf || w_b_inf)                     w_s1.sp = SP_INF;
    else if (w_a_zero || w_b_zero)                   w_s1.sp = SP_ZERO;
    else                                             w_s1.sp = SP_NONE;
  end

  assign w_prod = {{SIG_W{1'b0}}, r_s1.sig[PROD_W-1:SIG_W]} * {{SIG_W{1'b0}}, r_s1.sig[SIG_W-1:0]};

  fp_round_pack u_round_pack (
    .i_prod (r_s2.sig),
    .i_exp  (r_s2.exp),
    .i_sign (r_s2.sign),
    .o_word (w_rounded)
  );

  always_comb begin
    w_s3_word = w_rounded;
    case (r_s2.sp)
      SP_NAN:  w_s3_word = QNAN;
      SP_INF:  w_s3_word = r_s2.sign ? NEG_INF : POS_INF;
      SP_ZERO: w_s3_word = {r_s2.sign, 31'd0};
      default: w_s3_word = w_rounded;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_s3_valid <= 1'b0;
      r_s3_word  <= '0;
      R_valid    <= 1'b0;
      R          <= '0;
    end else begin
      r_s1       <= w_s1;
      r_s2       <= r_s1;
      r_s2.sig   <= w_prod;
      r_s3_valid <= r_s2.valid;
      r_s3_word  <= w_s3_word;
      R_valid    <= r_s3_valid;
      if (r_s3_valid) R <= r_s3_word;
    end
  end
endmodule

// File: tb/tb_fp_mul.sv
// tb/tb_fp_mul.sv - directed-vector self-checking bench for fp_mul
module tb_fp_mul;
  logic        CLK = 1'b0;
  logic        RST;
  logic        A_valid;
  logic [31:0] A;
  logic        B_valid;
  logic [31:0] B;
  logic        R_valid;
  logic [31:0] R;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_rv    = 0;
  int          rv0;
  logic [31:0] exp_cur = '0;
  logic [31:0] last_r  = '0;
  logic [31:0] exp_q[$];
  int          cyc_q[$];

  localparam int NV = 17;
  logic [31:0] va [NV] = '{32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h3F800001, 32'h3FFFFFFE,
                           32'h3FFFFFFF, 32'h7F000000, 32'h7F7FFFFF, 32'h00800000, 32'h7F800000,
                           32'h7FC00001, 32'hFF800000, 32'h80000000, 32'h80400000, 32'h00000001,
                           32'h3F800000, 32'h00000000};
  logic [31:0] vb [NV] = '{32'h3FC00000, 32'h40400000, 32'h3F800001, 32'h3FC00000, 32'h3F800001,
                           32'h3F800001, 32'h7F000000, 32'h3F800001, 32'h00800000, 32'h00000000,
                           32'h3F800000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h3F800000,
                           32'h7F800001, 32'hFF800000};
  logic [31:0] ve [NV] = '{32'h40100000, 32'hC0C00000, 32'h3F800002, 32'h3FC00002, 32'h40000000,
                           32'h40000000, 32'h7F800000, 32'h7F800000, 32'h00000000, 32'h7FC00000,
                           32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h80000000, 32'h00000000,
                           32'h7FC00000, 32'h7FC00000};

  fp_mul dut (
    .CLK     (CLK),
    .RST     (RST),
    .A_valid (A_valid),
    .A       (A),
    .B_valid (B_valid),
    .B       (B),
    .R_valid (R_valid),
    .R       (R)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [31:0] a, input logic bv, input logic [31:0] b,
                       input logic [31:0] e);
    A_valid = av;
    A       = a;
    B_valid = bv;
    B       = b;
    exp_cur = e;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  // Scoreboard: record each issue with its cycle, match results in order.
  always @(posedge CLK) begin
    cyc++;
    if (!RST && A_valid && B_valid) begin
      exp_q.push_back(exp_cur);
      cyc_q.push_back(cyc);
    end
  end

  always @(negedge CLK) begin
    if (R_valid) begin
      n_rv++;
      check("rvalid_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        check("result", R, exp_q.pop_front());
        check("latency", 32'(cyc - cyc_q.pop_front()), 32'd3);
      end
    end else if (!RST) begin
      check("hold", R, last_r);
    end
    last_r = R;
  end

  initial begin
    RST = 1'b1;
    A_valid = 1'b0; A = '0; B_valid = 1'b0; B = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_R", R, 32'h0);
    check("reset_R_valid", {31'd0, R_valid}, 32'd0);
    RST = 1'b0;
    idle(2);

    rv0 = n_rv;
    for (int i = 0; i < 20; i++) drive(1'b1, 32'h40000000, 1'b1, 32'h40400000, 32'h40C00000);
    idle(4);
    check("stream_count", 32'(n_rv - rv0), 32'd20);

    for (int i = 0; i < NV; i++) drive(1'b1, va[i], 1'b1, vb[i], ve[i]);
    idle(5);

    rv0 = n_rv;
    drive(1'b1, 32'h3F800000, 1'b0, 32'h40000000, 32'h0);
    drive(1'b1, 32'h3F800000, 1'b0, 32'h40000000, 32'h0);
    drive(1'b1, 32'h40000000, 1'b1, 32'h40400000, 32'h40C00000);
    idle(5);
    check("gap_pulse_count", 32'(n_rv - rv0), 32'd1);

    drive(1'b1, 32'h3FC00000, 1'b1, 32'h3FC00000, 32'h40100000);
    drive(1'b1, 32'hC0000000, 1'b1, 32'h40400000, 32'hC0C00000);
    A_valid = 1'b0;
    B_valid = 1'b0;
    check("pre_reset_R", R, 32'h40C00000);
    RST = 1'b1;
    #1;
    check("midreset_R", R, 32'h0);
    check("midreset_R_valid", {31'd0, R_valid}, 32'd0);
    exp_q.delete();
    cyc_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    rv0 = n_rv;
    idle(6);
    check("no_stale_rvalid", 32'(n_rv - rv0), 32'd0);

    drive(1'b1, 32'h3F800001, 1'b1, 32'h3F800001, 32'h3F800002);
    idle(5);
    check("post_reset_pulse", 32'(n_rv - rv0), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_mul.md
FP_MUL -- requirements
Module: fp_mul

Interface
REQ-001 Parameters: none; fixed IEEE-754 binary32 operands and result.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 A_valid  input  1  operand A valid this cycle.
REQ-005 A  input  32  operand A, binary32 (sign[31], exp[30:23], frac[22:0]).
REQ-006 B_valid  input  1  operand B valid this cycle.
REQ-007 B  input  32  operand B, binary32.
REQ-008 R_valid  output  1  result valid strobe, registered.
REQ-009 R  output  32  product A*B, binary32, registered.

Function
REQ-010 An operation issues on a rising CLK edge where A_valid=1 and B_valid=1; if either is 0, nothing issues and A/B are ignored.
REQ-011 Fixed latency of 3 cycles: an operation issued at edge N drives R and R_valid=1 after edge N+3.
REQ-012 Fully pipelined: one new operation accepted every cycle, no backpressure, no stall; results leave in issue order.
REQ-013 R_valid is high for exactly one cycle per issued operation; continuous valid input gives continuous R_valid after the 3-cycle fill.
REQ-014 When R_valid=0, R holds its last value.
REQ-015 Pipeline stages:
  - Stage 1: unpack, classify, sign = A[31]^B[31], biased exponent sum minus 127 (10-bit signed).
  - Stage 2: 24x24 significand product (48 bits).
  - Stage 3: normalize, round, pack.
REQ-016 Normalize: if product bit 47 is set, shift right by one and increment the exponent.
REQ-017 Rounding: round-to-nearest, ties-to-even, using guard, round and sticky bits; mantissa carry-out renormalizes and increments the exponent.
REQ-018 Subnormal inputs are treated as signed zero (flush-to-zero).
REQ-019 Results below the normal range are returned as signed zero; no subnormal outputs.
REQ-020 Exponent overflow after rounding (biased exponent >= 255) returns signed infinity.
REQ-021 Special cases, in priority order:
  - Any NaN input -> 0x7FC00000 (canonical quiet NaN).
  - Inf * zero -> 0x7FC00000.
  - Inf * finite non-zero -> signed infinity.
  - Zero * finite -> signed zero.
REQ-022 No exception flags are produced.

Reset
REQ-023 While RST=1, regardless of CLK: R=0x00000000, R_valid=0, and all pipeline valid bits cleared.
REQ-024 Operations in flight when RST asserts are discarded and never produce R_valid.
REQ-025 After RST deasserts, the first issue edge yields R_valid exactly 3 cycles later.

Structure
REQ-026 Shared package holds binary32 field widths, bias (127), and the constants QNAN=0x7FC00000, POS_INF=0x7F800000 and NEG_INF=0xFF800000.
REQ-027 Shared package holds the per-stage pipeline record typedef (valid, sign, exponent, significand, special-case code).
REQ-028 One sub-module, fp_round_pack: takes the normalized 48-bit product, exponent and sign, and returns the rounded binary32 word with overflow/underflow handling.
REQ-029 Stages 1-2 and the pipeline registers live in fp_mul.

Verification
REQ-030 Hold A=0x40000000 (2.0), B=0x40400000 (3.0), both valids high for 20 cycles -> R_valid rises 3 cycles after the first edge, then R=0x40C00000 (6.0) every cycle.
REQ-031 Exact and sign cases: A=0x3FC00000, B=0x3FC00000 -> R=0x40100000 (2.25); A=0xC0000000, B=0x40400000 -> R=0xC0C00000 (-6.0).
REQ-032 Rounding: A=0x3F800001, B=0x3F800001 -> R=0x3F800002.
REQ-033 Limits and specials:
  - 0x7F000000 * 0x7F000000 -> 0x7F800000 (overflow to +Inf).
  - 0x00800000 * 0x00800000 -> 0x00000000 (underflow to zero).
  - 0x7F800000 * 0x00000000 -> 0x7FC00000 (NaN).
  - 0x7FC00001 * 0x3F800000 -> 0x7FC00000 (NaN propagation).
REQ-034 Handshake gaps: A_valid=1 with B_valid=0 for 2 cycles, then both high for 1 cycle -> exactly one R_valid pulse, 3 cycles after the issuing edge.
REQ-035 Reset: assert RST mid-stream with 2 operations in flight -> R=0 and R_valid=0 immediately, and no stale R_valid after RST releases.
